// File: rtl/ber_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ber_pkg
// Description : Shared types, width helpers and saturating arithmetic for the
//               self-sequencing BER checker.
// Revision    : 1.0  initial release
// ============================================================================
package ber_pkg;

    // Operating phase of the checker
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_COUNT = 2'd2
    } ber_state_e;

    // Default geometry of the checker
    localparam int unsigned DEF_PRBS_LEN = 511;
    localparam int unsigned DEF_SYNC_WIN = 511;
    localparam int unsigned DEF_LOCK_WIN = 1024;

    // Width of a counter that must hold 0..n-1, never narrower than one bit
    function automatic int unsigned ber_cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_W  = ber_cnt_w(DEF_PRBS_LEN);
    localparam int unsigned SWIN_W = ber_cnt_w(DEF_SYNC_WIN);
    localparam int unsigned LWIN_W = ber_cnt_w(DEF_LOCK_WIN);

    // a + b clamped to max_v; operands are zero-extended by the caller
    function automatic logic [63:0] ber_sat_add(input logic [63:0] a,
                                                input logic [63:0] b,
                                                input logic [63:0] max_v);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max_v}) begin
            return max_v;
        end
        return s[63:0];
    endfunction

endpackage : ber_pkg
`default_nettype wire

// File: rtl/ber_win_acc.sv
`default_nettype none
// ============================================================================
// Module      : ber_win_acc
// Description : Windowed error accumulator. Counts enabled bits and their
//               errors; on the last bit of a WIN-bit window it pulses o_tc,
//               presents the window total (including that bit) on o_sum and
//               restarts from zero.
// Revision    : 1.0  initial release
// ============================================================================
module ber_win_acc
    import ber_pkg::*;
#(
    parameter int unsigned WIN = 511
) (
    input  logic                       clk,
    input  logic                       i_reset,
    input  logic                       i_clr,
    input  logic                       i_en,
    input  logic                       i_err,
    output logic                       o_tc,
    output logic [$clog2(WIN+1)-1:0]   o_sum
);

    localparam int unsigned c_CNT_W = ber_cnt_w(WIN);
    localparam int unsigned c_SUM_W = $clog2(WIN + 1);

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [c_SUM_W-1:0] acc_q, acc_d;

    assign o_tc  = i_en && (cnt_q == c_CNT_W'(WIN - 1));
    assign o_sum = acc_q + c_SUM_W'(i_err);

    // Next window position and running error sum
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (i_clr) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (i_en) begin
            if (o_tc) begin
                cnt_d = '0;
                acc_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = o_sum;
            end
        end
    end

    // Window registers
    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule : ber_win_acc
`default_nettype wire

// File: rtl/ber_checker_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ber_checker_fsm
// Description : Self-sequencing BER checker for one PRBS bit stream. Searches
//               every latency hypothesis of a local reference shifter, locks
//               on the best one, then counts errors/bits and drops back to a
//               fresh search when a lock window shows too many errors.
// Revision    : 1.0  initial release
// ============================================================================
module ber_checker_fsm
    import ber_pkg::*;
#(
    parameter int unsigned PRBS_LEN     = 511,
    parameter int unsigned SYNC_WIN     = 511,
    parameter int unsigned LOCK_WIN     = 1024,
    parameter int unsigned LOCK_ERR_MAX = 64,
    parameter int unsigned SYNC_ERR_MAX = 32,
    parameter int unsigned BER_DEN      = 50,
    parameter int unsigned CNT_W        = 64
) (
    input  logic                          clk,
    input  logic                          i_reset,
    input  logic                          i_ctrl,
    input  logic                          i_enable,
    input  logic                          i_clear,
    input  logic                          i_rx_bit,
    input  logic                          i_ref_bit,
    output logic [1:0]                    o_state,
    output logic                          o_locked,
    output logic [$clog2(PRBS_LEN)-1:0]   o_lat,
    output logic [CNT_W-1:0]              o_err_cnt,
    output logic [CNT_W-1:0]              o_tot_cnt,
    output logic [7:0]                    o_resync_cnt,
    output logic                          o_ber_ok
);

    localparam int unsigned c_IDX_W  = $clog2(PRBS_LEN);
    localparam int unsigned c_SSUM_W = $clog2(SYNC_WIN + 1);
    localparam int unsigned c_LSUM_W = $clog2(LOCK_WIN + 1);
    localparam int unsigned c_MUL_W  = CNT_W + $clog2(BER_DEN + 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    ber_state_e           state_q, state_d;
    logic [PRBS_LEN-1:0]  shifter_q, shifter_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic [c_IDX_W-1:0]   best_q, best_d;
    logic [c_IDX_W-1:0]   lat_q, lat_d;
    logic [c_SSUM_W-1:0]  err_min_q, err_min_d;
    logic [CNT_W-1:0]     err_q, err_d;
    logic [CNT_W-1:0]     tot_q, tot_d;
    logic [7:0]           resync_q, resync_d;
    logic                 ber_ok_q;

    logic                 w_sync_en, w_sync_clr, w_sync_tc, w_sync_e;
    logic [c_SSUM_W-1:0]  w_sync_sum;
    logic                 w_lock_en, w_lock_clr, w_lock_tc, w_lock_e;
    logic [c_LSUM_W-1:0]  w_lock_sum;
    logic                 w_better;
    logic [c_SSUM_W-1:0]  w_min_eff;
    logic [c_IDX_W-1:0]   w_best_eff;
    logic [PRBS_LEN-1:0]  w_shifted;
    logic [c_MUL_W-1:0]   w_err_scaled;

    // Error of the hypothesis under test and of the locked latency
    assign w_sync_e  = shifter_q[idx_q] ^ i_rx_bit;
    assign w_lock_e  = shifter_q[lat_q] ^ i_rx_bit;
    assign w_shifted = {shifter_q[PRBS_LEN-2:0], i_ref_bit};

    // Strictly better only: on a tie the earlier hypothesis is kept
    assign w_better   = (w_sync_sum < err_min_q);
    assign w_min_eff  = w_better ? w_sync_sum : err_min_q;
    assign w_best_eff = w_better ? idx_q : best_q;

    assign w_err_scaled = c_MUL_W'(err_q) * c_MUL_W'(BER_DEN);

    // Per-hypothesis error window used during the search
    ber_win_acc #(
        .WIN (SYNC_WIN)
    ) u_sync_win (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clr   (w_sync_clr),
        .i_en    (w_sync_en),
        .i_err   (w_sync_e),
        .o_tc    (w_sync_tc),
        .o_sum   (w_sync_sum)
    );

    // Lock-quality window used while counting
    ber_win_acc #(
        .WIN (LOCK_WIN)
    ) u_lock_win (
        .clk     (clk),
        .i_reset (i_reset),
        .i_clr   (w_lock_clr),
        .i_en    (w_lock_en),
        .i_err   (w_lock_e),
        .o_tc    (w_lock_tc),
        .o_sum   (w_lock_sum)
    );

    // Next-state, search bookkeeping and counter updates on each strobe
    always_comb begin
        state_d    = state_q;
        shifter_d  = shifter_q;
        idx_d      = idx_q;
        best_d     = best_q;
        lat_d      = lat_q;
        err_min_d  = err_min_q;
        err_d      = err_q;
        tot_d      = tot_q;
        resync_d   = resync_q;
        w_sync_en  = 1'b0;
        w_sync_clr = 1'b0;
        w_lock_en  = 1'b0;
        w_lock_clr = 1'b0;

        if (i_ctrl) begin
            if (!i_enable) begin
                // Abort whatever is running; counters keep their values
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d    = ST_SYNC;
                        idx_d      = '0;
                        best_d     = '0;
                        err_min_d  = '1;
                        w_sync_clr = 1'b1;
                    end

                    ST_SYNC: begin
                        shifter_d = w_shifted;
                        w_sync_en = 1'b1;
                        if (w_sync_tc) begin
                            if (idx_q == c_IDX_W'(PRBS_LEN - 1)) begin
                                if (w_min_eff <= c_SSUM_W'(SYNC_ERR_MAX)) begin
                                    state_d    = ST_COUNT;
                                    lat_d      = w_best_eff;
                                    err_d      = '0;
                                    tot_d      = '0;
                                    w_lock_clr = 1'b1;
                                end else begin
                                    // No hypothesis good enough: search again
                                    idx_d     = '0;
                                    best_d    = '0;
                                    err_min_d = '1;
                                end
                            end else begin
                                idx_d     = idx_q + 1'b1;
                                best_d    = w_best_eff;
                                err_min_d = w_min_eff;
                            end
                        end
                    end

                    ST_COUNT: begin
                        shifter_d = w_shifted;
                        w_lock_en = 1'b1;
                        if (i_clear) begin
                            err_d = '0;
                            tot_d = '0;
                        end else begin
                            err_d = CNT_W'(ber_sat_add(64'(err_q), 64'(w_lock_e),
                                                       64'(c_CNT_MAX)));
                            tot_d = CNT_W'(ber_sat_add(64'(tot_q), 64'd1,
                                                       64'(c_CNT_MAX)));
                        end
                        if (w_lock_tc && (w_lock_sum > c_LSUM_W'(LOCK_ERR_MAX))) begin
                            state_d    = ST_SYNC;
                            resync_d   = 8'(ber_sat_add(64'(resync_q), 64'd1, 64'd255));
                            idx_d      = '0;
                            best_d     = '0;
                            err_min_d  = '1;
                            w_sync_clr = 1'b1;
                        end
                    end

                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            shifter_q <= '0;
            idx_q     <= '0;
            best_q    <= '0;
            lat_q     <= '0;
            err_min_q <= '1;
            err_q     <= '0;
            tot_q     <= '0;
            resync_q  <= '0;
        end else begin
            state_q   <= state_d;
            shifter_q <= shifter_d;
            idx_q     <= idx_d;
            best_q    <= best_d;
            lat_q     <= lat_d;
            err_min_q <= err_min_d;
            err_q     <= err_d;
            tot_q     <= tot_d;
            resync_q  <= resync_d;
        end
    end

    // BER threshold flag, re-evaluated every clock from the live counters
    always_ff @(posedge clk) begin
        if (i_reset) begin
            ber_ok_q <= 1'b0;
        end else begin
            ber_ok_q <= (w_err_scaled < c_MUL_W'(tot_q));
        end
    end

    assign o_state      = state_q;
    assign o_locked     = (state_q == ST_COUNT);
    assign o_lat        = lat_q;
    assign o_err_cnt    = err_q;
    assign o_tot_cnt    = tot_q;
    assign o_resync_cnt = resync_q;
    assign o_ber_ok     = ber_ok_q;

endmodule : ber_checker_fsm
`default_nettype wire
